// File: rtl/move_object_ctrl.sv
// Per-frame position controller for the movable square: commits a Y step, lets the
// collision flags re-settle, then commits an X step, with edge clamping and blocking.
module move_object_ctrl #(
    parameter int X_INI      = 100,
    parameter int Y_INI      = 120,
    parameter int STEP       = 4,
    parameter int X_MAX      = 640,
    parameter int Y_MAX      = 480,
    parameter int DIV_FRAMES = 2,
    parameter int SETTLE_CYC = 2
) (
    input  logic       VGA_clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic [6:0] tamanho,
    input  logic       colisao_min_y,
    input  logic       colisao_max_y,
    input  logic       colisao_min_x,
    input  logic       colisao_max_x,
    output logic [9:0] xPos,
    output logic [8:0] yPos,
    output logic       moving,
    output logic       blocked,
    output logic       frame_overrun
);

    localparam int DIV_W = (DIV_FRAMES > 1) ? $clog2(DIV_FRAMES) : 1;
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_FRAMES - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [9:0]  STEP_Y = 10'(STEP);
    localparam logic [10:0] STEP_X = 11'(STEP);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE_Y,
        EVAL_Y,
        SETTLE_X,
        EVAL_X,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [9:0]       x_q, x_d;
    logic [8:0]       y_q, y_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [3:0]       key_l_q, key_l_d;      // {up, down, left, right}
    logic             blk_l_q, blk_l_d;
    logic             blocked_q, blocked_d;
    logic             overrun_q, overrun_d;

    // Clamp arithmetic is done one bit wider than the position so nothing wraps.
    logic [9:0]  y_ext, y_lim, y_sum, y_dn;
    logic [8:0]  y_up;
    logic [10:0] x_ext, x_lim, x_sum, x_dn;
    logic [9:0]  x_up;

    always_comb begin
        y_ext = {1'b0, y_q};
        y_lim = 10'(Y_MAX) - {3'b000, tamanho};
        y_sum = y_ext + STEP_Y;
        y_dn  = (y_sum > y_lim) ? y_lim : y_sum;
        y_up  = (y_ext < STEP_Y) ? 9'd0 : 9'(y_ext - STEP_Y);

        x_ext = {1'b0, x_q};
        x_lim = 11'(X_MAX) - {4'b0000, tamanho};
        x_sum = x_ext + STEP_X;
        x_dn  = (x_sum > x_lim) ? x_lim : x_sum;
        x_up  = (x_ext < STEP_X) ? 10'd0 : 10'(x_ext - STEP_X);
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        div_cnt_d    = div_cnt_q;
        settle_cnt_d = settle_cnt_q;
        key_l_d      = key_l_q;
        blk_l_d      = blk_l_q;
        blocked_d    = blocked_q;
        overrun_d    = 1'b0;

        // A tick arriving mid-move is dropped and reported, div_cnt untouched.
        if (state_q != IDLE && frame_tick) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_d    = '0;
                        key_l_d      = {key_up, key_down, key_left, key_right};
                        settle_cnt_d = '0;
                        state_d      = SETTLE_Y;
                    end else begin
                        div_cnt_d = div_cnt_q + 1'b1;
                    end
                end
            end
            SETTLE_Y, SETTLE_X: begin
                if (settle_cnt_q == SET_LAST) begin
                    settle_cnt_d = '0;
                    state_d      = (state_q == SETTLE_Y) ? EVAL_Y : EVAL_X;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            EVAL_Y: begin
                if (key_l_q[3] && !key_l_q[2]) begin
                    if (colisao_min_y) blk_l_d = 1'b1;
                    else               y_d     = y_up;
                end else if (key_l_q[2] && !key_l_q[3]) begin
                    if (colisao_max_y) blk_l_d = 1'b1;
                    else               y_d     = 9'(y_dn);
                end
                state_d = SETTLE_X;
            end
            EVAL_X: begin
                if (key_l_q[1] && !key_l_q[0]) begin
                    if (colisao_min_x) blk_l_d = 1'b1;
                    else               x_d     = x_up;
                end else if (key_l_q[0] && !key_l_q[1]) begin
                    if (colisao_max_x) blk_l_d = 1'b1;
                    else               x_d     = 10'(x_dn);
                end
                state_d = DONE;
            end
            DONE: begin
                blocked_d = blk_l_q;
                blk_l_d   = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            state_q      <= IDLE;
            x_q          <= 10'(X_INI);
            y_q          <= 9'(Y_INI);
            div_cnt_q    <= '0;
            settle_cnt_q <= '0;
            key_l_q      <= '0;
            blk_l_q      <= 1'b0;
            blocked_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            div_cnt_q    <= div_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            key_l_q      <= key_l_d;
            blk_l_q      <= blk_l_d;
            blocked_q    <= blocked_d;
            overrun_q    <= overrun_d;
        end
    end

    assign xPos          = x_q;
    assign yPos          = y_q;
    assign moving        = (state_q != IDLE);
    assign blocked       = blocked_q;
    assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_move_object_ctrl.sv
// Directed bench for move_object_ctrl: per-feature tasks with hand-computed positions.
module tb_move_object_ctrl;

    logic       VGA_clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       key_up, key_down, key_left, key_right;
    logic [6:0] tamanho;
    logic       colisao_min_y, colisao_max_y, colisao_min_x, colisao_max_x;
    logic [9:0] xPos;
    logic [8:0] yPos;
    logic       moving, blocked, frame_overrun;

    int checks = 0;
    int errors = 0;

    always #5 VGA_clk = ~VGA_clk;

    move_object_ctrl dut (
        .VGA_clk       (VGA_clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .key_up        (key_up),
        .key_down      (key_down),
        .key_left      (key_left),
        .key_right     (key_right),
        .tamanho       (tamanho),
        .colisao_min_y (colisao_min_y),
        .colisao_max_y (colisao_max_y),
        .colisao_min_x (colisao_min_x),
        .colisao_max_x (colisao_max_x),
        .xPos          (xPos),
        .yPos          (yPos),
        .moving        (moving),
        .blocked       (blocked),
        .frame_overrun (frame_overrun)
    );

    // One frame_tick followed by enough idle cycles for a full move plus DONE.
    task automatic do_frame();
        @(negedge VGA_clk) frame_tick = 1'b1;
        @(negedge VGA_clk) frame_tick = 1'b0;
        repeat (8) @(negedge VGA_clk);
    endtask

    // With DIV_FRAMES=2 every second tick commits; div_cnt is 0 on entry.
    task automatic commit_frame();
        do_frame();
        do_frame();
    endtask

    task automatic test_reset();
        reset = 1'b1; frame_tick = 1'b0;
        key_up = 0; key_down = 0; key_left = 0; key_right = 0;
        colisao_min_y = 0; colisao_max_y = 0; colisao_min_x = 0; colisao_max_x = 0;
        tamanho = 7'd20;
        repeat (3) @(negedge VGA_clk);
        reset = 1'b0;
        checks++;
        if (xPos !== 10'd100 || yPos !== 9'd120 || moving !== 1'b0 || blocked !== 1'b0 || frame_overrun !== 1'b0) begin
            $display("FAIL reset: x=%0d y=%0d mv=%b blk=%b ovr=%b required x=100 y=120 mv=0 blk=0 ovr=0",
                     xPos, yPos, moving, blocked, frame_overrun);
            errors++;
        end
        $display("reset: x=%0d y=%0d", xPos, yPos);
    endtask

    task automatic test_divider();
        for (int i = 1; i <= 4; i++) begin
            @(negedge VGA_clk) frame_tick = 1'b1;
            @(negedge VGA_clk) frame_tick = 1'b0;
            checks++;
            if (moving !== ((i % 2) == 0)) begin
                $display("FAIL div_moving_tick%0d: moving=%b required=%b", i, moving, (i % 2) == 0);
                errors++;
            end
            repeat (8) @(negedge VGA_clk);
            $display("tick %0d: moving=%b", i, moving);
        end
        checks++;
        if (xPos !== 10'd100 || yPos !== 9'd120) begin
            $display("FAIL div_nokeys: x=%0d y=%0d required x=100 y=120", xPos, yPos);
            errors++;
        end
    endtask

    task automatic test_down();
        int exp_y[2] = '{124, 128};
        key_down = 1'b1;
        for (int i = 0; i < 2; i++) begin
            commit_frame();
            checks++;
            if (yPos !== 9'(exp_y[i]) || xPos !== 10'd100 || blocked !== 1'b0) begin
                $display("FAIL down_step%0d: y=%0d x=%0d blk=%b required y=%0d x=100 blk=0",
                         i, yPos, xPos, blocked, exp_y[i]);
                errors++;
            end
            $display("down step %0d: y=%0d", i, yPos);
        end
        key_down = 1'b0;
    endtask

    task automatic test_block_up();
        key_up = 1'b1; colisao_min_y = 1'b1;
        commit_frame();
        checks++;
        if (yPos !== 9'd128 || blocked !== 1'b1) begin
            $display("FAIL up_blocked: y=%0d blk=%b required y=128 blk=1", yPos, blocked);
            errors++;
        end
        $display("up blocked: y=%0d blk=%b", yPos, blocked);
        colisao_min_y = 1'b0;
        commit_frame();
        checks++;
        if (yPos !== 9'd124 || blocked !== 1'b0) begin
            $display("FAIL up_released: y=%0d blk=%b required y=124 blk=0", yPos, blocked);
            errors++;
        end
        $display("up released: y=%0d blk=%b", yPos, blocked);
        key_up = 1'b0;
    endtask

    task automatic test_clamps();
        tamanho = 7'd22;
        key_down = 1'b1;
        for (int i = 0; i < 90; i++) commit_frame();
        checks++;
        if (yPos !== 9'd458) begin
            $display("FAIL clamp_bottom22: y=%0d required=458", yPos);
            errors++;
        end
        $display("bottom clamp size 22: y=%0d", yPos);
        tamanho = 7'd20;
        commit_frame();
        checks++;
        if (yPos !== 9'd460) begin
            $display("FAIL clamp_bottom20: y=%0d required=460", yPos);
            errors++;
        end
        $display("bottom clamp size 20: y=%0d", yPos);
        tamanho = 7'd22;
        commit_frame();
        key_down = 1'b0;
        key_up = 1'b1;
        for (int i = 0; i < 114; i++) commit_frame();
        checks++;
        if (yPos !== 9'd2) begin
            $display("FAIL walk_up_to_2: y=%0d required=2", yPos);
            errors++;
        end
        $display("walk up: y=%0d", yPos);
        commit_frame();
        checks++;
        if (yPos !== 9'd0 || blocked !== 1'b0) begin
            $display("FAIL clamp_top: y=%0d blk=%b required y=0 blk=0", yPos, blocked);
            errors++;
        end
        $display("top clamp: y=%0d", yPos);
        key_up = 1'b0;
        tamanho = 7'd20;
    endtask

    task automatic test_diag_block();
        key_down = 1'b1;
        commit_frame();
        commit_frame();
        key_down = 1'b0;
        key_up = 1'b1; key_right = 1'b1;
        do_frame();
        @(negedge VGA_clk) frame_tick = 1'b1;
        @(negedge VGA_clk) frame_tick = 1'b0;
        repeat (3) @(negedge VGA_clk);
        checks++;
        if (yPos !== 9'd4) begin
            $display("FAIL diag_y: y=%0d required=4", yPos);
            errors++;
        end
        colisao_max_x = 1'b1;
        repeat (5) @(negedge VGA_clk);
        checks++;
        if (xPos !== 10'd100 || yPos !== 9'd4 || blocked !== 1'b1) begin
            $display("FAIL diag_x_blocked: x=%0d y=%0d blk=%b required x=100 y=4 blk=1",
                     xPos, yPos, blocked);
            errors++;
        end
        $display("diagonal: x=%0d y=%0d blk=%b", xPos, yPos, blocked);
        colisao_max_x = 1'b0; key_up = 1'b0;
        commit_frame();
        checks++;
        if (xPos !== 10'd104 || yPos !== 9'd4 || blocked !== 1'b0) begin
            $display("FAIL right_step: x=%0d y=%0d blk=%b required x=104 y=4 blk=0",
                     xPos, yPos, blocked);
            errors++;
        end
        $display("right step: x=%0d", xPos);
    endtask

    task automatic test_overrun();
        do_frame();
        @(negedge VGA_clk) frame_tick = 1'b1;
        @(negedge VGA_clk) frame_tick = 1'b0;
        repeat (3) @(negedge VGA_clk);
        frame_tick = 1'b1;
        @(negedge VGA_clk) frame_tick = 1'b0;
        checks++;
        if (frame_overrun !== 1'b1) begin
            $display("FAIL overrun_pulse: frame_overrun=%b required=1", frame_overrun);
            errors++;
        end
        @(negedge VGA_clk);
        checks++;
        if (frame_overrun !== 1'b0 || moving !== 1'b1) begin
            $display("FAIL overrun_end: frame_overrun=%b moving=%b required ovr=0 mv=1",
                     frame_overrun, moving);
            errors++;
        end
        repeat (3) @(negedge VGA_clk);
        checks++;
        if (xPos !== 10'd108 || yPos !== 9'd4) begin
            $display("FAIL overrun_move: x=%0d y=%0d required x=108 y=4", xPos, yPos);
            errors++;
        end
        $display("overrun move: x=%0d", xPos);
        do_frame();
        checks++;
        if (xPos !== 10'd108) begin
            $display("FAIL dropped_tick_div: x=%0d required=108", xPos);
            errors++;
        end
        do_frame();
        checks++;
        if (xPos !== 10'd112) begin
            $display("FAIL after_drop_commit: x=%0d required=112", xPos);
            errors++;
        end
        $display("after dropped tick: x=%0d", xPos);
        key_right = 1'b0;
    endtask

    task automatic test_reset_mid_move();
        key_down = 1'b1;
        do_frame();
        @(negedge VGA_clk) frame_tick = 1'b1;
        @(negedge VGA_clk) frame_tick = 1'b0;
        repeat (2) @(negedge VGA_clk);
        reset = 1'b1;
        @(negedge VGA_clk);
        reset = 1'b0;
        checks++;
        if (xPos !== 10'd100 || yPos !== 9'd120 || moving !== 1'b0 || blocked !== 1'b0) begin
            $display("FAIL reset_mid_move: x=%0d y=%0d mv=%b blk=%b required x=100 y=120 mv=0 blk=0",
                     xPos, yPos, moving, blocked);
            errors++;
        end
        $display("reset mid move: x=%0d y=%0d", xPos, yPos);
        key_down = 1'b0;
    endtask

    initial begin
        test_reset();
        test_divider();
        test_down();
        test_block_up();
        test_clamps();
        test_diag_block();
        test_overrun();
        test_reset_mid_move();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
